// File: rtl/cpfifo_pkg.sv
// Shared sizing helpers and types for cond_port_fifo.
// Optional level/almost-full ports are enabled with CPFIFO_LEVEL_PORTS_EN.
package cpfifo_pkg;

    function automatic int calc_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

endpackage

// File: rtl/cond_port_fifo_ram.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Used by cond_port_fifo, whose CPFIFO_LEVEL_PORTS_EN option does not affect it.
module cond_port_fifo_ram
    import cpfifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_we,
    input  logic [calc_ptr_w(DEPTH)-1:0]  i_waddr,
    input  logic [WIDTH-1:0]              i_wdata,
    input  logic [calc_ptr_w(DEPTH)-1:0]  i_raddr,
    output logic [WIDTH-1:0]              o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/cond_port_fifo.sv
// Show-ahead synchronous FIFO with registered status and error pulses.
// Define CPFIFO_LEVEL_PORTS_EN to add ALMOST_FULL_TH, o_level and o_almost_full.
module cond_port_fifo
    import cpfifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
`ifdef CPFIFO_LEVEL_PORTS_EN
    ,
    parameter int ALMOST_FULL_TH = DEPTH - 2
`endif
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    output logic                         o_full,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_empty,
    output logic                         o_overflow,
    output logic                         o_underflow
`ifdef CPFIFO_LEVEL_PORTS_EN
    ,
    output logic [calc_cnt_w(DEPTH)-1:0] o_level,
    output logic                         o_almost_full
`endif
);

    localparam int PTR_W = calc_ptr_w(DEPTH);
    localparam int CNT_W = calc_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    err_flags_t       err_q, err_d;
    logic             pop_ok;
    logic             push_ok;

    // Pointer, occupancy and flag next-state.
    always_comb begin
        pop_ok  = i_pop & ~empty_q;
        // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
        push_ok = i_push & (~full_q | pop_ok);

        rptr_d = pop_ok  ? (rptr_q + PTR_W'(1'b1)) : rptr_q;
        wptr_d = push_ok ? (wptr_q + PTR_W'(1'b1)) : wptr_q;

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase

        empty_d         = (count_d == {CNT_W{1'b0}});
        full_d          = (count_d == DEPTH_C);
        err_d.overflow  = i_push & ~push_ok;
        err_d.underflow = i_pop & ~pop_ok;
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rptr_q  <= {PTR_W{1'b0}};
            wptr_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    cond_port_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (push_ok),
        .i_waddr (wptr_q),
        .i_wdata (i_data),
        .i_raddr (rptr_q),
        .o_rdata (o_data)
    );

    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_overflow  = err_q.overflow;
    assign o_underflow = err_q.underflow;

`ifdef CPFIFO_LEVEL_PORTS_EN
    logic almost_full_q, almost_full_d;

    always_comb begin
        almost_full_d = (count_d >= CNT_W'(ALMOST_FULL_TH));
    end

    // Almost-full flag register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign o_level       = count_q;
    assign o_almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_cond_port_fifo.sv
// Randomised and directed bench for cond_port_fifo against a queue-based model.
// Works with or without CPFIFO_LEVEL_PORTS_EN defined.
module tb_cond_port_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int TH    = 6;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             i_clk;
    logic             i_rst;
    logic             i_push;
    logic             i_pop;
    logic [WIDTH-1:0] i_data;
    logic [WIDTH-1:0] o_data;
    logic             o_full;
    logic             o_empty;
    logic             o_overflow;
    logic             o_underflow;
`ifdef CPFIFO_LEVEL_PORTS_EN
    logic [CNT_W-1:0] o_level;
    logic             o_almost_full;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [WIDTH-1:0] q[$];
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;

    cond_port_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
`ifdef CPFIFO_LEVEL_PORTS_EN
        ,
        .ALMOST_FULL_TH (TH)
`endif
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (i_push),
        .i_data      (i_data),
        .o_full      (o_full),
        .i_pop       (i_pop),
        .o_data      (o_data),
        .o_empty     (o_empty),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
`ifdef CPFIFO_LEVEL_PORTS_EN
        ,
        .o_level       (o_level),
        .o_almost_full (o_almost_full)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its queue.
    task automatic step(input bit ps, input bit pp, input logic [WIDTH-1:0] d);
        bit pop_ok;
        bit push_ok;
        i_push  = ps;
        i_pop   = pp;
        i_data  = d;
        pop_ok  = pp && (q.size() > 0);
        push_ok = ps && ((q.size() < DEPTH) || pop_ok);
        @(posedge i_clk);
        #1;
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(d);
        m_ovf = ps && !push_ok;
        m_unf = pp && !pop_ok;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 8'h00);
        idle();
    endtask

    // Per-cycle comparison of every DUT output with the model.
    always @(negedge i_clk) begin
        if (chk_en && !i_rst) begin
            chk("cyc_empty", o_empty, q.size() == 0);
            chk("cyc_full", o_full, q.size() == DEPTH);
            chk("cyc_overflow", o_overflow, m_ovf);
            chk("cyc_underflow", o_underflow, m_unf);
            if (q.size() > 0) chk("cyc_data", o_data, q[0]);
`ifdef CPFIFO_LEVEL_PORTS_EN
            chk("cyc_level", o_level, q.size());
            chk("cyc_almost_full", o_almost_full, q.size() >= TH);
`endif
        end
    end

    initial begin
        i_push = 1'b0;
        i_pop  = 1'b0;
        i_data = 8'h00;
        i_rst  = 1'b0;
        #1 i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_underflow", o_underflow, 0);
`ifdef CPFIFO_LEVEL_PORTS_EN
        chk("rst_level", o_level, 0);
        chk("rst_almost_full", o_almost_full, 0);
`endif
        @(negedge i_clk);
        i_rst  = 1'b0;
        chk_en = 1'b1;
        idle();
        chk("idle_empty", o_empty, 1);

        // Fill, overflow, then drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, WIDTH'(i));
`ifdef CPFIFO_LEVEL_PORTS_EN
            if (i == TH) begin
                chk("af_rise", o_almost_full, 1);
                chk("af_level", o_level, 6);
            end
`endif
        end
        chk("fill_full", o_full, 1);
        chk("fill_head", o_data, 8'h01);
        step(1'b1, 1'b0, 8'h99);
        chk("ovf_pulse", o_overflow, 1);
        idle();
        chk("ovf_clear", o_overflow, 0);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain_order", o_data, i);
            step(1'b0, 1'b1, 8'h00);
        end
        chk("drain_empty", o_empty, 1);

        // Simultaneous push and pop while full.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, WIDTH'(i));
        step(1'b1, 1'b1, 8'hAA);
        chk("fullpp_full", o_full, 1);
        chk("fullpp_ovf", o_overflow, 0);
        chk("fullpp_head", o_data, 8'h02);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 8'h00);
        chk("fullpp_aa", o_data, 8'hAA);
        step(1'b0, 1'b1, 8'h00);
        chk("fullpp_empty", o_empty, 1);

        // Simultaneous push and pop while empty.
        step(1'b1, 1'b1, 8'h55);
        chk("emptypp_unf", o_underflow, 1);
        chk("emptypp_empty", o_empty, 0);
        chk("emptypp_data", o_data, 8'h55);
        drain();

        // Wrap with a 3-entry backlog.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, WIDTH'(8'h30 + i));
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b0, WIDTH'(8'h40 + i));
            else            step(1'b0, 1'b1, 8'h00);
        end
        drain();

`ifdef CPFIFO_LEVEL_PORTS_EN
        for (int i = 0; i < TH; i++) step(1'b1, 1'b0, WIDTH'(8'h60 + i));
        chk("af_six", o_almost_full, 1);
        step(1'b0, 1'b1, 8'h00);
        chk("af_fall", o_almost_full, 0);
        chk("af_level5", o_level, 5);
        drain();
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45),
                 WIDTH'($urandom));
        end

        // Asynchronous reset in the middle of a burst.
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h12);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_empty", o_empty, 1);
        chk("arst_full", o_full, 0);
        chk("arst_overflow", o_overflow, 0);
        chk("arst_underflow", o_underflow, 0);
`ifdef CPFIFO_LEVEL_PORTS_EN
        chk("arst_level", o_level, 0);
        chk("arst_almost_full", o_almost_full, 0);
`endif
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        step(1'b1, 1'b0, 8'h77);
        chk("post_rst_data", o_data, 8'h77);
        chk("post_rst_empty", o_empty, 0);
        idle();
        drain();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_port_fifo.md
Name: cond_port_fifo

Overview:
Parametrised synchronous show-ahead FIFO for generic datapath buffering between two handshaking stages in the same clock domain. Width and depth are generalised. Status ports for fill level and almost-full are compiled in or out by a preprocessor macro, together with their threshold parameter. Overflow and underflow events are reported as registered single-cycle pulses.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
ALMOST_FULL_TH, DEPTH-2, level at or above which o_almost_full asserts; exists only when CPFIFO_LEVEL_PORTS_EN is defined

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_push  input  1  write request
i_data  input  WIDTH  write data
o_full  output  1  no free entry
i_pop  input  1  read request
o_data  output  WIDTH  head-of-queue data, valid while o_empty=0
o_empty  output  1  no stored entry
o_overflow  output  1  one-cycle pulse: push rejected on previous cycle
o_underflow  output  1  one-cycle pulse: pop rejected on previous cycle
o_level  output  $clog2(DEPTH+1)  current entry count (CPFIFO_LEVEL_PORTS_EN only)
o_almost_full  output  1  o_level >= ALMOST_FULL_TH (CPFIFO_LEVEL_PORTS_EN only)

Behaviour:
- Clocking: one clock, i_clk. Reset is asynchronous and active-high on i_rst.
- Reset values: rptr=0, wptr=0, count=0, o_empty=1, o_full=0, o_overflow=0, o_underflow=0, o_level=0, o_almost_full=0. Storage array is not reset.
- Reset asserted mid-operation discards all contents immediately. The first push after release is accepted on the first rising edge at which i_rst=0.
- pop_ok = i_pop & ~o_empty.
- push_ok = i_push & (~o_full | pop_ok). When full, a simultaneous push and pop are both accepted, and count is unchanged.
- When empty with simultaneous push and pop: pop is rejected (underflow pulse), push is accepted, count becomes 1. There is no bypass of write data to o_data in the same cycle.
- Write latency: data pushed at edge N appears on o_data after edge N when the FIFO was empty. o_empty falls in that same cycle.
- o_data = mem[rptr], combinational from registered state. Its value while empty is don't-care.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count is $clog2(DEPTH+1) bits wide. It updates as +1 on push only, -1 on pop only, and holds otherwise.
- o_empty and o_full are registered, derived from next count: 0 for empty, DEPTH for full.
- o_overflow <= i_push & ~push_ok.
- o_underflow <= i_pop & ~pop_ok.
- A rejected push or pop never changes state other than the error pulse.
- Outputs are stable between edges; no output depends combinationally on i_push or i_pop.

Optional Feature:
Macro CPFIFO_LEVEL_PORTS_EN.
- Defined:
  - The ALMOST_FULL_TH parameter exists.
  - Ports o_level and o_almost_full exist.
  - o_level = count.
  - o_almost_full is registered and equals (next count >= ALMOST_FULL_TH). Its reset value is 0.
- Undefined:
  - The parameter and both ports are absent from the parameter and port lists. List separators stay legal in both builds.
  - The almost-full comparator is not instantiated.
  - All other behaviour is identical.

Decomposition:
- Package cpfifo_pkg holds:
  - function calc_ptr_w(depth) returning $clog2(depth)
  - function calc_cnt_w(depth) returning $clog2(depth+1)
  - typedef for the error-flag pair struct {overflow, underflow}
- One sub-module: cond_port_fifo_ram, a DEPTH x WIDTH register array with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- Pointer, count and flag logic stay in the top module.

Test Plan:
- Reset then idle with push and pop both 0 -> o_empty=1, o_full=0, o_overflow=0, o_underflow=0. With macro: o_level=0, o_almost_full=0.
- WIDTH=8, DEPTH=8: push 0x01..0x08 on consecutive cycles -> o_full=1 after 8th edge. A 9th push gives o_overflow=1 for one cycle. Pop 8 times returns 0x01..0x08 in order, then o_empty=1.
- When full, push 0xAA and pop together -> 0x01 leaves, count stays 8, no overflow pulse. 0xAA is read out 8 pops later.
- When empty, push 0x55 and pop together -> o_underflow=1 next cycle, o_empty=0, o_data=0x55.
- Wrap test: 20 cycles of push and pop alternating with a 3-entry backlog -> data order is preserved across pointer wrap.
- Macro on, ALMOST_FULL_TH=6: push 6 entries -> o_almost_full rises after 6th edge with o_level=6. One pop -> o_almost_full=0, o_level=5. Assert reset mid-burst -> all status returns to reset values asynchronously.
